rr_mux_arbiter: RTL

RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

---
 rtl/rr_mux_pkg.sv | 37 +++
 rtl/rr_mux_arbiter_mux.sv | 10 +
 rtl/rr_mux_arbiter.sv | 117 +++++++++++
 3 files changed

// File: rtl/rr_mux_pkg.sv
// Shared definitions for the round-robin mux arbiter: state encoding, requester
// count, default hold limit and the round-robin winner search.
package rr_mux_pkg;

    localparam int NUM_REQ      = 4;
    localparam int MAX_HOLD_DEF = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Returns the first set bit of req found scanning from ptr+1 upward, wrapping 3->0.
    function automatic logic [1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                           input logic [1:0]         ptr);
        logic [1:0] idx;
        logic [1:0] win;
        logic       found;
        win   = ptr;
        found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = ptr + 2'(i);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [1:0] idx);
        logic [NUM_REQ-1:0] v;
        v = NUM_REQ'(1) << idx;
        return v;
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_mux.sv
// Shared 4:1 single-bit data mux.
module rr_mux_arbiter_mux (
    output logic       z,
    input  logic [3:0] a,
    input  logic [1:0] s
);

    assign z = a[s];

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter with a bounded hold time, steering four requesters'
// data bits through one shared mux and registering the selected bit.
module rr_mux_arbiter
    import rr_mux_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] a,
    output logic [3:0] gnt,
    output logic [1:0] s,
    output logic       busy,
    output logic       z,
    output logic       z_valid
);

    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    state_t             state_p0, nxt_state;
    logic [NUM_REQ-1:0] gnt_p0, nxt_gnt;
    logic [1:0]         s_p0, nxt_s;
    logic [1:0]         ptr_p0, nxt_ptr;
    logic [3:0]         hold_p0, nxt_hold;
    logic               z_p1;
    logic               vld_p1;
    logic               mux_out;
    logic [NUM_REQ-1:0] others;
    logic [1:0]         win;

    always_comb begin
        nxt_state = state_p0;
        nxt_gnt   = gnt_p0;
        nxt_s     = s_p0;
        nxt_ptr   = ptr_p0;
        nxt_hold  = hold_p0;
        others    = req & ~gnt_p0;
        win       = rr_pick(others, ptr_p0);

        case (state_p0)
            IDLE: begin
                if (req != '0) begin
                    win       = rr_pick(req, ptr_p0);
                    nxt_state = GRANT;
                    nxt_gnt   = onehot(win);
                    nxt_s     = win;
                    nxt_ptr   = win;
                    nxt_hold  = '0;
                end
            end
            GRANT: begin
                if (!req[s_p0] || hold_p0 == HOLD_LAST) begin
                    nxt_hold = '0;
                    if (others != '0) begin
                        nxt_gnt = onehot(win);
                        nxt_s   = win;
                        nxt_ptr = win;
                    end else if (!req[s_p0]) begin
                        // Owner gone and nobody waiting: release; s keeps the last owner.
                        nxt_state = IDLE;
                        nxt_gnt   = '0;
                    end
                end else begin
                    nxt_hold = hold_p0 + 4'd1;
                end
            end
            default: begin
                nxt_state = IDLE;
                nxt_gnt   = '0;
            end
        endcase
    end

    // Stage p0: arbitration state and grant registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_p0 <= IDLE;
            gnt_p0   <= '0;
            s_p0     <= 2'd0;
            ptr_p0   <= 2'd3;
            hold_p0  <= '0;
        end else begin
            state_p0 <= nxt_state;
            gnt_p0   <= nxt_gnt;
            s_p0     <= nxt_s;
            ptr_p0   <= nxt_ptr;
            hold_p0  <= nxt_hold;
        end
    end

    rr_mux_arbiter_mux u_mux (
        .z (mux_out),
        .a (a),
        .s (s_p0)
    );

    // Stage p1: registered mux output; z only moves on granted cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            z_p1   <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= (state_p0 == GRANT);
            if (state_p0 == GRANT) begin
                z_p1 <= mux_out;
            end
        end
    end

    assign gnt     = gnt_p0;
    assign s       = s_p0;
    assign busy    = (state_p0 == GRANT);
    assign z       = z_p1;
    assign z_valid = vld_p1;

endmodule
